// File: rtl/mips_trace_pkg.sv
`default_nettype none
// ============================================================================
// Package     : mips_trace_pkg
// Description : Shared constants and record layout for the MIPS32 write-back
//               commit-trace buffer.
// Revision    : 1.0  initial release
// ============================================================================
package mips_trace_pkg;

   localparam int REG_ADDR_W = 5;
   localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
   localparam int DROP_CNT_W = 16;

   // Record layout at the default widths (16-bit stamp, 32-bit data).
   localparam int TRC_CYC_W  = 16;
   localparam int TRC_DATA_W = 32;

   typedef struct packed {
      logic [TRC_CYC_W-1:0]  cycle;
      logic                  src;
      logic [REG_ADDR_W-1:0] addr;
      logic [TRC_DATA_W-1:0] data;
   } trace_rec_t;

   localparam int TRACE_REC_W = $bits(trace_rec_t);

   // Packed record width for arbitrary stamp/data widths.
   function automatic int trace_rec_width(input int cyc_w, input int data_w);
      return cyc_w + 1 + REG_ADDR_W + data_w;
   endfunction

endpackage : mips_trace_pkg
`default_nettype wire

// File: rtl/wb_trace_fifo.sv
`default_nettype none
// ============================================================================
// Module      : wb_trace_fifo
// Description : Generic synchronous first-word-fall-through FIFO. A push into
//               a full FIFO is accepted only when a pop frees the slot in the
//               same cycle. While empty, rd_data holds the last popped word
//               (zero after reset or clear).
// Revision    : 1.0  initial release
// ============================================================================
module wb_trace_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   clear,
   input  logic                   push,
   input  logic                   pop,
   input  logic [WIDTH-1:0]       wr_data,
   output logic [WIDTH-1:0]       rd_data,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   cnt;
   logic [WIDTH-1:0] last_pop;
   logic             do_pop;
   logic             do_push;

   assign empty   = (cnt == '0);
   assign full    = (cnt == FULL_CNT);
   assign count   = cnt;
   assign do_pop  = pop && !empty && !clear;
   assign do_push = push && !clear && (!full || do_pop);
   assign rd_data = empty ? last_pop : mem[rd_ptr];

   // Storage array: written only on an accepted push, never reset.
   always_ff @(posedge clk) begin
      if (reset && do_push)
         mem[wr_ptr] <= wr_data;
   end

   // Pointers, occupancy and the hold register shown while empty.
   always_ff @(posedge clk) begin
      if (!reset || clear) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         cnt      <= '0;
         last_pop <= '0;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop) begin
            rd_ptr   <= rd_ptr + PTR_W'(1);
            last_pop <= mem[rd_ptr];
         end
         if (do_push && !do_pop)
            cnt <= cnt + (PTR_W+1)'(1);
         else if (do_pop && !do_push)
            cnt <= cnt - (PTR_W+1)'(1);
      end
   end

endmodule : wb_trace_fifo
`default_nettype wire

// File: rtl/mips_wb_trace_buffer.sv
`default_nettype none
// ============================================================================
// Module      : mips_wb_trace_buffer
// Description : Passive commit-trace buffer on the MIPS32 write-back stage.
//               Captures retiring register writes with a cycle stamp into a
//               FWFT FIFO; records arriving while full are dropped and counted.
//               Optional macro WB_TRACE_FILTER_EN adds a per-register capture
//               mask input (reg_mask).
// Revision    : 1.0  initial release
// ============================================================================
module mips_wb_trace_buffer
   import mips_trace_pkg::*;
#(
   parameter int DEPTH  = 16,
   parameter int CYC_W  = 16,
   parameter int DATA_W = 32
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   en,
   input  logic                   clear,
`ifdef WB_TRACE_FILTER_EN
   input  logic [31:0]            reg_mask,
`endif
   input  logic                   wb_reg_write,
   input  logic [REG_ADDR_W-1:0]  wb_addr,
   input  logic [DATA_W-1:0]      wb_data,
   input  logic                   wb_mem_to_reg,
   output logic                   trc_valid,
   input  logic                   trc_ready,
   output logic [CYC_W-1:0]       trc_cycle,
   output logic [REG_ADDR_W-1:0]  trc_addr,
   output logic [DATA_W-1:0]      trc_data,
   output logic                   trc_src,
   output logic [$clog2(DEPTH):0] count,
   output logic                   overflow,
   output logic [DROP_CNT_W-1:0]  drop_cnt
);

   localparam int REC_W = trace_rec_width(CYC_W, DATA_W);

   logic [CYC_W-1:0] cycle_cnt;
   logic             capture;
   logic             reg_sel;
   logic             pop;
   logic             drop;
   logic             fifo_full;
   logic             fifo_empty;
   logic [REC_W-1:0] wr_rec;
   logic [REC_W-1:0] rd_rec;

`ifdef WB_TRACE_FILTER_EN
   assign reg_sel = reg_mask[wb_addr];
`else
   assign reg_sel = 1'b1;
`endif

   assign capture   = en && wb_reg_write && (wb_addr != REG_ZERO) && reg_sel;
   assign trc_valid = !fifo_empty;
   assign pop       = trc_valid && trc_ready;
   // A full FIFO still accepts the record when the head leaves this cycle.
   assign drop      = capture && fifo_full && !pop && !clear;
   assign wr_rec    = {cycle_cnt, wb_mem_to_reg, wb_addr, wb_data};
   assign {trc_cycle, trc_src, trc_addr, trc_data} = rd_rec;

   // Free-running stamp: advances on every enabled edge, wraps naturally.
   always_ff @(posedge clk) begin
      if (!reset || clear)
         cycle_cnt <= '0;
      else if (en)
         cycle_cnt <= cycle_cnt + CYC_W'(1);
   end

   // Drop accounting: sticky flag plus saturating counter.
   always_ff @(posedge clk) begin
      if (!reset || clear) begin
         overflow <= 1'b0;
         drop_cnt <= '0;
      end else if (drop) begin
         overflow <= 1'b1;
         if (drop_cnt != {DROP_CNT_W{1'b1}})
            drop_cnt <= drop_cnt + DROP_CNT_W'(1);
      end
   end

   wb_trace_fifo #(
      .WIDTH (REC_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .clear   (clear),
      .push    (capture),
      .pop     (pop),
      .wr_data (wr_rec),
      .rd_data (rd_rec),
      .count   (count),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

endmodule : mips_wb_trace_buffer
`default_nettype wire

// File: tb/tb_mips_wb_trace_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_wb_trace_buffer
// Description : Directed, scoreboard-checked bench for mips_wb_trace_buffer.
//               Honours WB_TRACE_FILTER_EN when defined.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mips_wb_trace_buffer;

   localparam int DEPTH  = 16;
   localparam int CYC_W  = 16;
   localparam int DATA_W = 32;

   typedef struct {
      logic [15:0] cyc;
      logic        src;
      logic [4:0]  addr;
      logic [31:0] data;
   } rec_t;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        en = 1'b0;
   logic        clear = 1'b0;
   logic [31:0] reg_mask = 32'hFFFF_FFFF;
   logic        wb_reg_write = 1'b0;
   logic [4:0]  wb_addr = '0;
   logic [31:0] wb_data = '0;
   logic        wb_mem_to_reg = 1'b0;
   logic        trc_valid;
   logic        trc_ready = 1'b0;
   logic [15:0] trc_cycle;
   logic [4:0]  trc_addr;
   logic [31:0] trc_data;
   logic        trc_src;
   logic [4:0]  count;
   logic        overflow;
   logic [15:0] drop_cnt;

   // Scoreboard and reference model state
   rec_t        q[$];
   rec_t        m_last = '{default: '0};
   logic [15:0] m_cyc  = '0;
   logic [15:0] m_drop = '0;
   logic        m_ovf  = 1'b0;
   int          ncmp   = 0;
   int          nfail  = 0;

   always #5 clk = ~clk;

   mips_wb_trace_buffer #(
      .DEPTH  (DEPTH),
      .CYC_W  (CYC_W),
      .DATA_W (DATA_W)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .en            (en),
      .clear         (clear),
`ifdef WB_TRACE_FILTER_EN
      .reg_mask      (reg_mask),
`endif
      .wb_reg_write  (wb_reg_write),
      .wb_addr       (wb_addr),
      .wb_data       (wb_data),
      .wb_mem_to_reg (wb_mem_to_reg),
      .trc_valid     (trc_valid),
      .trc_ready     (trc_ready),
      .trc_cycle     (trc_cycle),
      .trc_addr      (trc_addr),
      .trc_data      (trc_data),
      .trc_src       (trc_src),
      .count         (count),
      .overflow      (overflow),
      .drop_cnt      (drop_cnt)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Compare every visible output against the model.
   task automatic check_outputs();
      rec_t h;
      h = (q.size() != 0) ? q[0] : m_last;
      chk("trc_valid", trc_valid, q.size() != 0);
      chk("count", count, q.size());
      chk("overflow", overflow, m_ovf);
      chk("drop_cnt", drop_cnt, m_drop);
      chk("trc_cycle", trc_cycle, h.cyc);
      chk("trc_addr", trc_addr, h.addr);
      chk("trc_data", trc_data, h.data);
      chk("trc_src", trc_src, h.src);
   endtask

   // Check, advance the model for the coming edge, then take the edge.
   task automatic tick();
      logic m_pop;
      logic m_cap;
      check_outputs();
      m_pop = (q.size() != 0) && trc_ready;
      m_cap = en && wb_reg_write && (wb_addr != 5'd0);
`ifdef WB_TRACE_FILTER_EN
      m_cap = m_cap && reg_mask[wb_addr];
`endif
      if (clear) begin
         q.delete();
         m_cyc  = '0;
         m_drop = '0;
         m_ovf  = 1'b0;
         m_last = '{default: '0};
      end else begin
         if (m_pop)
            m_last = q.pop_front();
         if (m_cap) begin
            if (q.size() < DEPTH)
               q.push_back('{m_cyc, wb_mem_to_reg, wb_addr, wb_data});
            else begin
               m_ovf = 1'b1;
               if (m_drop != 16'hFFFF) m_drop++;
            end
         end
         if (en) m_cyc++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic s);
      wb_reg_write  = 1'b1;
      wb_addr       = a;
      wb_data       = d;
      wb_mem_to_reg = s;
      tick();
      wb_reg_write  = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      @(posedge clk);
      #1;
      reset  = 1'b1;
      q.delete();
      m_cyc  = '0;
      m_drop = '0;
      m_ovf  = 1'b0;
      m_last = '{default: '0};
   endtask

   task automatic drain(input int n);
      trc_ready = 1'b1;
      for (int i = 0; i < n; i++) tick();
      trc_ready = 1'b0;
   endtask

   initial begin
      // Reset state
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      check_outputs();
      chk("rst_cycle", trc_cycle, 16'd0);

      // 1: first capture stamped with counter value 3
      en = 1'b1;
      repeat (3) tick();
      wr(5'd8, 32'h9999_9999, 1'b0);
      chk("t1_valid", trc_valid, 1'b1);
      chk("t1_addr", trc_addr, 5'd8);
      chk("t1_data", trc_data, 32'h9999_9999);
      chk("t1_src", trc_src, 1'b0);
      chk("t1_cycle", trc_cycle, 16'd3);
      chk("t1_count", count, 5'd1);

      // 2: write to $zero is ignored
      wr(5'd0, 32'hDEAD_BEEF, 1'b0);
      chk("t2_count", count, 5'd1);
      chk("t2_drop", drop_cnt, 16'd0);
      drain(2);

      // 3: overfill by four
      for (int i = 1; i <= 20; i++) wr(5'd9, 32'(i), 1'b1);
      chk("t3_count", count, 5'd16);
      chk("t3_ovf", overflow, 1'b1);
      chk("t3_drop", drop_cnt, 16'd4);
      chk("t3_head", trc_data, 32'd1);

      // 4: full FIFO with simultaneous pop and push
      trc_ready = 1'b1;
      wr(5'd10, 32'd100, 1'b0);
      chk("t4_count", count, 5'd16);
      chk("t4_drop", drop_cnt, 16'd4);
      chk("t4_head", trc_data, 32'd2);
      drain(18);

      // 5: streaming with consumer always ready
      clear = 1'b1;
      tick();
      clear = 1'b0;
      trc_ready = 1'b1;
      for (int i = 0; i < 24; i++) begin
         chk("t5_count_le1", count <= 5'd1, 1'b1);
         wr(5'(8 + (i % 21)), $urandom, 1'b0);
      end
      chk("t5_ovf", overflow, 1'b0);
      drain(2);

      // 6a: clear with queued entries and a simultaneous capture
      for (int i = 0; i < 5; i++) wr(5'd11, 32'h100 + 32'(i), 1'b1);
      chk("t6_count5", count, 5'd5);
      clear = 1'b1;
      wr(5'd12, 32'h5555_AAAA, 1'b0);
      clear = 1'b0;
      chk("t6_clr_count", count, 5'd0);
      chk("t6_clr_valid", trc_valid, 1'b0);
      chk("t6_clr_data", trc_data, 32'd0);
      wr(5'd13, 32'h0000_0013, 1'b0);
      chk("t6_clr_stamp", trc_cycle, 16'd0);

      // 6b: reset with queued entries
      for (int i = 0; i < 3; i++) wr(5'd14, 32'h200 + 32'(i), 1'b0);
      do_reset();
      check_outputs();
      chk("t6_rst_count", count, 5'd0);
      wr(5'd15, 32'h0000_0015, 1'b1);
      chk("t6_rst_stamp", trc_cycle, 16'd0);
      drain(2);

`ifdef WB_TRACE_FILTER_EN
      // Filter: only $t0 passes
      reg_mask = 32'h0000_0100;
      wr(5'd8, 32'hA, 1'b0);
      wr(5'd9, 32'hB, 1'b0);
      wr(5'd10, 32'hC, 1'b0);
      chk("flt_count", count, 5'd1);
      chk("flt_addr", trc_addr, 5'd8);
      chk("flt_drop", drop_cnt, 16'd0);
      drain(2);
      reg_mask = 32'hFFFF_FFFF;
`endif

      check_outputs();
      chk("end_empty", q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule : tb_mips_wb_trace_buffer
`default_nettype wire
